spike_train_buffer: RTL and testbench



---
 rtl/snn_pkg.sv | 27 ++
 rtl/spike_train_buffer_if.sv | 39 +++
 rtl/spike_ram.sv | 34 +++
 rtl/spike_train_buffer.sv | 156 +++++++++++++++
 tb/tb_spike_train_buffer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared constants, width helpers and FSM state encoding for the spike train buffer.
package snn_pkg;

    localparam int unsigned TIME_STEPS_DEF        = 3;
    localparam int unsigned OUT_CHANNELS_DEF      = 16;
    localparam int unsigned FRAME_WIDTH_DEF       = 6;
    localparam int unsigned PE_ARRAY_ROW_SIZE_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FULL  = 2'd3
    } state_t;

    function automatic int unsigned entry_count(input int unsigned ts, input int unsigned oc);
        return ts * oc;
    endfunction

    function automatic int unsigned stamp_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    localparam int unsigned TS_W_DEF = stamp_width(TIME_STEPS_DEF);
    localparam int unsigned OC_W_DEF = stamp_width(OUT_CHANNELS_DEF);

endpackage

// File: rtl/spike_train_buffer_if.sv
// Producer/consumer handshake bundle between two spiking layers and the buffer.
interface spike_train_buffer_if
    import snn_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH       = FRAME_WIDTH_DEF,
    parameter int unsigned PE_ARRAY_ROW_SIZE = PE_ARRAY_ROW_SIZE_DEF,
    parameter int unsigned TS_W              = TS_W_DEF,
    parameter int unsigned OC_W              = OC_W_DEF
);
    localparam int unsigned EW = FRAME_WIDTH * FRAME_WIDTH;

    logic                                 new_spk_train_ready;
    logic [PE_ARRAY_ROW_SIZE-1:0][EW-1:0] spk_arr;
    logic [TS_W-1:0]                      prev_time_step;
    logic [OC_W-1:0]                      prev_oc_phase;
    logic                                 post_syn_RAM_loaded;
    logic                                 pre_syn_RAM_loaded;
    logic                                 rd_en;
    logic [TS_W-1:0]                      rd_ts;
    logic [OC_W-1:0]                      rd_oc;
    logic [EW-1:0]                        rd_data;
    logic                                 rd_valid;
    logic                                 rd_done;
    logic                                 overflow;
    logic                                 count_err;

    modport master (
        output new_spk_train_ready, spk_arr, prev_time_step, prev_oc_phase,
               post_syn_RAM_loaded, rd_en, rd_ts, rd_oc, rd_done,
        input  pre_syn_RAM_loaded, rd_data, rd_valid, overflow, count_err
    );

    modport slave (
        input  new_spk_train_ready, spk_arr, prev_time_step, prev_oc_phase,
               post_syn_RAM_loaded, rd_en, rd_ts, rd_oc, rd_done,
        output pre_syn_RAM_loaded, rd_data, rd_valid, overflow, count_err
    );

endinterface

// File: rtl/spike_ram.sv
// Simple dual-port spike map storage; read data is registered and reads as zero when not requested.
module spike_ram #(
    parameter int unsigned DEPTH = 48,
    parameter int unsigned WIDTH = 36,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !rd_en) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/spike_train_buffer.sv
// Collects PE-row spike maps for a whole layer pass, then serves them to the next layer until released.
module spike_train_buffer
    import snn_pkg::*;
#(
    parameter int unsigned TIME_STEPS        = TIME_STEPS_DEF,
    parameter int unsigned OUT_CHANNELS      = OUT_CHANNELS_DEF,
    parameter int unsigned FRAME_WIDTH       = FRAME_WIDTH_DEF,
    parameter int unsigned PE_ARRAY_ROW_SIZE = PE_ARRAY_ROW_SIZE_DEF
) (
    input logic                  clk,
    input logic                  rst,
    spike_train_buffer_if.slave  bus
);

    localparam int unsigned ENTRIES = entry_count(TIME_STEPS, OUT_CHANNELS);
    localparam int unsigned EW      = FRAME_WIDTH * FRAME_WIDTH;
    localparam int unsigned TS_W    = stamp_width(TIME_STEPS);
    localparam int unsigned OC_W    = stamp_width(OUT_CHANNELS);
    localparam int unsigned AW      = $clog2(ENTRIES);
    localparam int unsigned PHASES  = OUT_CHANNELS / PE_ARRAY_ROW_SIZE;
    localparam int unsigned PULSES  = ENTRIES / PE_ARRAY_ROW_SIZE;
    localparam int unsigned CNT_W   = $clog2(PULSES + 1) + 1;
    localparam int unsigned ROW_W   = (PE_ARRAY_ROW_SIZE > 1) ? $clog2(PE_ARRAY_ROW_SIZE) : 1;

    state_t                               state;
    state_t                               state_next;
    logic [PE_ARRAY_ROW_SIZE-1:0][EW-1:0] hold_rows;
    logic [TS_W-1:0]                      hold_ts;
    logic [OC_W-1:0]                      hold_oc;
    logic [ROW_W-1:0]                     row_idx;
    logic [CNT_W-1:0]                     pulse_cnt;
    logic                                 done_pending;
    logic                                 full_flag;
    logic                                 valid_flag;
    logic                                 overflow_flag;
    logic                                 count_err_flag;
    logic [EW-1:0]                        ram_q;

    logic            accept_c;
    logic            stamp_ok_c;
    logic            last_row_c;
    logic            wr_en_c;
    logic            rd_ok_c;
    logic [AW-1:0]   wr_addr_c;
    logic [AW-1:0]   rd_addr_c;

    assign stamp_ok_c = (32'(bus.prev_time_step) < TIME_STEPS) && (32'(bus.prev_oc_phase) < PHASES);
    assign last_row_c = (row_idx == ROW_W'(PE_ARRAY_ROW_SIZE - 1));
    // A reset landing mid-drain must not commit the row in flight.
    assign wr_en_c    = (state == ST_DRAIN) && !rst;
    assign wr_addr_c  = AW'(32'(hold_ts) * OUT_CHANNELS + 32'(hold_oc) * PE_ARRAY_ROW_SIZE + 32'(row_idx));
    assign rd_ok_c    = (state == ST_FULL) && bus.rd_en && (32'(bus.rd_ts) < TIME_STEPS)
                        && (32'(bus.rd_oc) < OUT_CHANNELS);
    assign rd_addr_c  = AW'(32'(bus.rd_ts) * OUT_CHANNELS + 32'(bus.rd_oc));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        case (state)
            ST_IDLE, ST_FILL: begin
                if (bus.new_spk_train_ready && stamp_ok_c) begin
                    state_next = ST_DRAIN;
                    accept_c   = 1'b1;
                end else if (bus.post_syn_RAM_loaded || done_pending) begin
                    state_next = ST_FULL;
                end
            end
            ST_DRAIN: begin
                if (last_row_c) begin
                    state_next = (done_pending || bus.post_syn_RAM_loaded) ? ST_FULL : ST_FILL;
                end
            end
            ST_FULL: begin
                if (bus.rd_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Holding registers, pulse bookkeeping and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_rows      <= '0;
            hold_ts        <= '0;
            hold_oc        <= '0;
            row_idx        <= '0;
            pulse_cnt      <= '0;
            done_pending   <= 1'b0;
            full_flag      <= 1'b0;
            valid_flag     <= 1'b0;
            overflow_flag  <= 1'b0;
            count_err_flag <= 1'b0;
        end else begin
            full_flag  <= (state_next == ST_FULL);
            valid_flag <= rd_ok_c;
            if (accept_c) begin
                hold_rows <= bus.spk_arr;
                hold_ts   <= bus.prev_time_step;
                hold_oc   <= bus.prev_oc_phase;
                row_idx   <= '0;
                if (pulse_cnt != '1) begin
                    pulse_cnt <= pulse_cnt + CNT_W'(1);
                end
            end else if (state == ST_DRAIN) begin
                row_idx <= row_idx + ROW_W'(1);
            end
            if (state == ST_FULL && bus.rd_done) begin
                pulse_cnt    <= '0;
                done_pending <= 1'b0;
            end else if (state != ST_FULL && bus.post_syn_RAM_loaded) begin
                done_pending <= 1'b1;
            end
            if (bus.new_spk_train_ready && (state == ST_DRAIN || state == ST_FULL)) begin
                overflow_flag <= 1'b1;
            end
            if (bus.new_spk_train_ready && (state == ST_IDLE || state == ST_FILL) && !stamp_ok_c) begin
                count_err_flag <= 1'b1;
            end
            if (state != ST_FULL && state_next == ST_FULL && pulse_cnt != CNT_W'(PULSES)) begin
                count_err_flag <= 1'b1;
            end
        end
    end

    spike_ram #(
        .DEPTH (ENTRIES),
        .WIDTH (EW),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_c),
        .wr_addr (wr_addr_c),
        .wr_data (hold_rows[row_idx]),
        .rd_en   (rd_ok_c),
        .rd_addr (rd_addr_c),
        .rd_data (ram_q)
    );

    assign bus.pre_syn_RAM_loaded = full_flag;
    assign bus.rd_valid           = valid_flag;
    assign bus.rd_data            = ram_q;
    assign bus.overflow           = overflow_flag;
    assign bus.count_err          = count_err_flag;

endmodule

// File: tb/tb_spike_train_buffer.sv
// Directed bench for spike_train_buffer: fill/read passes, overflow, short pass, mid-drain reset, bad stamps.
module tb_spike_train_buffer;

    localparam int unsigned TS   = 3;
    localparam int unsigned OC   = 16;
    localparam int unsigned FW   = 6;
    localparam int unsigned ROWS = 2;
    localparam int unsigned EW   = FW * FW;
    localparam int unsigned TS_W = 3;
    localparam int unsigned OC_W = 5;
    localparam int unsigned PH   = OC / ROWS;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [EW-1:0] exp_mem [TS*OC];

    always #5 clk = ~clk;

    spike_train_buffer_if #(
        .FRAME_WIDTH(FW), .PE_ARRAY_ROW_SIZE(ROWS), .TS_W(TS_W), .OC_W(OC_W)
    ) bus ();

    spike_train_buffer #(
        .TIME_STEPS(TS), .OUT_CHANNELS(OC), .FRAME_WIDTH(FW), .PE_ARRAY_ROW_SIZE(ROWS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [EW-1:0] pat(input int pass, input int ts, input int ph, input int r);
        return 36'(pass * 4096 + ts * 256 + ph * 16 + r) ^ 36'h9C3A596F0;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_pulse(input int ts, input int ph, input int pass, input bit post);
        bus.new_spk_train_ready = 1'b1;
        bus.prev_time_step      = TS_W'(ts);
        bus.prev_oc_phase       = OC_W'(ph);
        bus.spk_arr             = {pat(pass, ts, ph, 1), pat(pass, ts, ph, 0)};
        bus.post_syn_RAM_loaded = post;
    endtask

    task automatic note_model(input int ts, input int ph, input int pass);
        for (int r = 0; r < int'(ROWS); r++) begin
            exp_mem[ts*OC + ph*ROWS + r] = pat(pass, ts, ph, r);
        end
    endtask

    // One pulse, then idle long enough for the two-row drain to finish.
    task automatic send_pulse(input int ts, input int ph, input int pass, input bit post);
        @(negedge clk);
        set_pulse(ts, ph, pass, post);
        @(negedge clk);
        bus.new_spk_train_ready = 1'b0;
        bus.post_syn_RAM_loaded = 1'b0;
        @(negedge clk);
    endtask

    task automatic fill(input int pass, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            send_pulse(k / PH, k % PH, pass, 1'b0);
            note_model(k / PH, k % PH, pass);
        end
    endtask

    task automatic do_read(input int ts, input int oc, input bit ev, input logic [EW-1:0] ed,
                           input string tag);
        @(negedge clk);
        bus.rd_en = 1'b1;
        bus.rd_ts = TS_W'(ts);
        bus.rd_oc = OC_W'(oc);
        @(negedge clk);
        bus.rd_en = 1'b0;
        check({tag, "_valid"}, 64'(bus.rd_valid), 64'(ev));
        check({tag, "_data"}, 64'(bus.rd_data), 64'(ed));
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < int'(TS*OC); a++) begin
            do_read(a / OC, a % OC, 1'b1, exp_mem[a], $sformatf("%s_a%0d", tag, a));
        end
    endtask

    task automatic release_buf;
        @(negedge clk);
        bus.rd_done = 1'b1;
        @(negedge clk);
        bus.rd_done = 1'b0;
    endtask

    // Final pulse of a complete pass together with post_syn_RAM_loaded; full appears 3 cycles later.
    task automatic last_pulse(input int pass, input string tag);
        send_pulse(TS - 1, PH - 1, pass, 1'b1);
        note_model(TS - 1, PH - 1, pass);
        check({tag, "_pre_c2"}, 64'(bus.pre_syn_RAM_loaded), 64'd0);
        @(negedge clk);
        check({tag, "_pre_c3"}, 64'(bus.pre_syn_RAM_loaded), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst                     = 1'b1;
        bus.new_spk_train_ready = 1'b0;
        bus.spk_arr             = '0;
        bus.prev_time_step      = '0;
        bus.prev_oc_phase       = '0;
        bus.post_syn_RAM_loaded = 1'b0;
        bus.rd_en               = 1'b0;
        bus.rd_ts               = '0;
        bus.rd_oc               = '0;
        bus.rd_done             = 1'b0;
        for (int a = 0; a < int'(TS*OC); a++) exp_mem[a] = '0;
        repeat (3) @(negedge clk);
        check("rst_pre", 64'(bus.pre_syn_RAM_loaded), 64'd0);
        check("rst_valid", 64'(bus.rd_valid), 64'd0);
        check("rst_data", 64'(bus.rd_data), 64'd0);
        check("rst_ovf", 64'(bus.overflow), 64'd0);
        check("rst_cerr", 64'(bus.count_err), 64'd0);
        rst = 1'b0;

        // Pass 1: complete fill and readback.
        fill(1, 0, TS*PH - 2);
        last_pulse(1, "p1");
        check("p1_cerr", 64'(bus.count_err), 64'd0);
        check("p1_ovf", 64'(bus.overflow), 64'd0);
        read_all("p1");
        do_read(3, 0, 1'b0, '0, "bad_ts");
        do_read(0, 16, 1'b0, '0, "bad_oc");

        // Release with a read in the same cycle: the read still completes.
        @(negedge clk);
        bus.rd_en   = 1'b1;
        bus.rd_ts   = TS_W'(0);
        bus.rd_oc   = OC_W'(5);
        bus.rd_done = 1'b1;
        @(negedge clk);
        bus.rd_en   = 1'b0;
        bus.rd_done = 1'b0;
        check("done_rd_valid", 64'(bus.rd_valid), 64'd1);
        check("done_rd_data", 64'(bus.rd_data), 64'(exp_mem[5]));
        check("done_pre", 64'(bus.pre_syn_RAM_loaded), 64'd0);

        // Pass 2: read attempt in FILL, overflow pulse during the final drain.
        send_pulse(0, 0, 2, 1'b0);
        note_model(0, 0, 2);
        do_read(0, 0, 1'b0, '0, "rd_fill");
        fill(2, 1, TS*PH - 2);
        @(negedge clk);
        set_pulse(TS - 1, PH - 1, 2, 1'b1);
        note_model(TS - 1, PH - 1, 2);
        @(negedge clk);
        set_pulse(0, 0, 9, 1'b0);
        @(negedge clk);
        bus.new_spk_train_ready = 1'b0;
        check("p2_pre_c2", 64'(bus.pre_syn_RAM_loaded), 64'd0);
        @(negedge clk);
        check("p2_pre_c3", 64'(bus.pre_syn_RAM_loaded), 64'd1);
        check("p2_ovf", 64'(bus.overflow), 64'd1);
        check("p2_cerr", 64'(bus.count_err), 64'd0);
        read_all("p2");
        release_buf();
        check("p2_rel_pre", 64'(bus.pre_syn_RAM_loaded), 64'd0);

        // Pass 3: one pulse short, then post_syn_RAM_loaded alone.
        fill(3, 0, TS*PH - 2);
        @(negedge clk);
        bus.post_syn_RAM_loaded = 1'b1;
        @(negedge clk);
        bus.post_syn_RAM_loaded = 1'b0;
        check("p3_pre", 64'(bus.pre_syn_RAM_loaded), 64'd1);
        check("p3_cerr", 64'(bus.count_err), 64'd1);
        do_read(2, 14, 1'b1, exp_mem[46], "p3_stale");
        do_read(0, 0, 1'b1, exp_mem[0], "p3_new");
        release_buf();

        // Reset in the middle of a drain.
        @(negedge clk);
        set_pulse(1, 1, 4, 1'b0);
        @(negedge clk);
        bus.new_spk_train_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_pre", 64'(bus.pre_syn_RAM_loaded), 64'd0);
        check("mid_valid", 64'(bus.rd_valid), 64'd0);
        check("mid_data", 64'(bus.rd_data), 64'd0);
        check("mid_ovf", 64'(bus.overflow), 64'd0);
        check("mid_cerr", 64'(bus.count_err), 64'd0);

        // Pass 5: normal operation after the reset.
        fill(5, 0, TS*PH - 2);
        last_pulse(5, "p5");
        check("p5_cerr", 64'(bus.count_err), 64'd0);
        check("p5_ovf", 64'(bus.overflow), 64'd0);
        read_all("p5");
        release_buf();

        // Out-of-range time step on a pulse.
        send_pulse(3, 0, 6, 1'b0);
        check("bad_stamp_cerr", 64'(bus.count_err), 64'd1);
        check("bad_stamp_pre", 64'(bus.pre_syn_RAM_loaded), 64'd0);
        check("bad_stamp_ovf", 64'(bus.overflow), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
